// File: rtl/row_uram_arbiter_if.sv
// Bus bundle between the shared row URAM arbiter, its cores, the drain reader and the URAM macro port.
interface row_uram_arbiter_if #(
    parameter int NUM_CORES   = 4,
    parameter int URAM_ADDR_W = 12
);
    logic [NUM_CORES-1:0]             i_core_req;
    logic [NUM_CORES-1:0]             i_core_locked;
    logic [NUM_CORES-1:0]             o_core_grant;
    logic [NUM_CORES-1:0]             i_core_uram_en;
    logic [NUM_CORES-1:0]             i_core_uram_wr_en;
    logic [NUM_CORES*URAM_ADDR_W-1:0] i_core_uram_addr;
    logic [NUM_CORES*32-1:0]          i_core_uram_wr_data;
    logic                             i_drain_req;
    logic                             o_drain_grant;
    logic                             i_drain_en;
    logic [URAM_ADDR_W-1:0]           i_drain_addr;
    logic                             o_uram_en;
    logic                             o_uram_wr_en;
    logic [URAM_ADDR_W-1:0]           o_uram_addr;
    logic [31:0]                      o_uram_wr_data;
    logic                             o_uram_emptied;
    logic [URAM_ADDR_W:0]             o_wr_count;

    modport slave (
        input  i_core_req, i_core_locked, i_core_uram_en, i_core_uram_wr_en,
               i_core_uram_addr, i_core_uram_wr_data, i_drain_req, i_drain_en, i_drain_addr,
        output o_core_grant, o_drain_grant, o_uram_en, o_uram_wr_en, o_uram_addr,
               o_uram_wr_data, o_uram_emptied, o_wr_count
    );

    modport master (
        output i_core_req, i_core_locked, i_core_uram_en, i_core_uram_wr_en,
               i_core_uram_addr, i_core_uram_wr_data, i_drain_req, i_drain_en, i_drain_addr,
        input  o_core_grant, o_drain_grant, o_uram_en, o_uram_wr_en, o_uram_addr,
               o_uram_wr_data, o_uram_emptied, o_wr_count
    );
endinterface

// File: rtl/row_uram_arbiter.sv
// Round-robin arbiter sharing one row URAM between NUM_CORES cores and a priority drain reader.
module row_uram_arbiter #(
    parameter int NUM_CORES   = 4,
    parameter int URAM_ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    row_uram_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [URAM_ADDR_W:0] CNT_MAX = {1'b1, {URAM_ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, CORE, GAP, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       pick;
    logic                   pick_vld;
    int                     pick_idx;

    logic [NUM_CORES-1:0]   core_grant;
    logic                   sel_en, sel_wr_en;
    logic [URAM_ADDR_W-1:0] sel_addr;
    logic [31:0]            sel_wr_data;
    logic                   emptied_d;

    logic                   uram_en_q, uram_wr_en_q, emptied_q;
    logic [URAM_ADDR_W-1:0] uram_addr_q;
    logic [31:0]            uram_wr_data_q;
    logic [URAM_ADDR_W:0]   wr_count_q;

    // Scan downward so the requester closest at-or-after rr_ptr is the last (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        pick_idx = 0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            pick_idx = (int'(rr_ptr_q) + i) % NUM_CORES;
            if (bus.i_core_req[pick_idx]) begin
                pick     = PTR_W'(pick_idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (bus.i_drain_req) begin
                    state_d = DRAIN;
                end else if (pick_vld) begin
                    state_d = CORE;
                    owner_d = pick;
                end
            end
            CORE: begin
                if (!(bus.i_core_req[owner_q] || bus.i_core_locked[owner_q])) begin
                    state_d  = GAP;
                    rr_ptr_d = (int'(owner_q) == NUM_CORES - 1) ? '0 : owner_q + 1'b1;
                end
            end
            GAP:   state_d = IDLE;
            DRAIN: if (!bus.i_drain_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grants decode straight from flops; the URAM port mux feeds the output register.
    always_comb begin
        core_grant  = '0;
        sel_en      = 1'b0;
        sel_wr_en   = 1'b0;
        sel_addr    = '0;
        sel_wr_data = '0;
        case (state_q)
            CORE: begin
                core_grant[owner_q] = 1'b1;
                sel_en      = bus.i_core_uram_en[owner_q];
                sel_wr_en   = bus.i_core_uram_wr_en[owner_q];
                sel_addr    = bus.i_core_uram_addr[int'(owner_q)*URAM_ADDR_W +: URAM_ADDR_W];
                sel_wr_data = bus.i_core_uram_wr_data[int'(owner_q)*32 +: 32];
            end
            DRAIN: begin
                sel_en   = bus.i_drain_en;
                sel_addr = bus.i_drain_addr;
            end
            default: ;
        endcase
    end

    assign emptied_d = (state_q == DRAIN) && !bus.i_drain_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uram_en_q      <= 1'b0;
            uram_wr_en_q   <= 1'b0;
            uram_addr_q    <= '0;
            uram_wr_data_q <= '0;
            emptied_q      <= 1'b0;
            wr_count_q     <= '0;
        end else begin
            uram_en_q      <= sel_en;
            uram_wr_en_q   <= sel_wr_en;
            uram_addr_q    <= sel_addr;
            uram_wr_data_q <= sel_wr_data;
            emptied_q      <= emptied_d;
            if (emptied_d)
                wr_count_q <= '0;
            else if (sel_en && sel_wr_en && wr_count_q != CNT_MAX)
                wr_count_q <= wr_count_q + 1'b1;
        end
    end

    assign bus.o_core_grant   = core_grant;
    assign bus.o_drain_grant  = (state_q == DRAIN);
    assign bus.o_uram_en      = uram_en_q;
    assign bus.o_uram_wr_en   = uram_wr_en_q;
    assign bus.o_uram_addr    = uram_addr_q;
    assign bus.o_uram_wr_data = uram_wr_data_q;
    assign bus.o_uram_emptied = emptied_q;
    assign bus.o_wr_count     = wr_count_q;
endmodule
